frame_stream_ctrl: RTL
======================

Name: frame_stream_ctrl

Overview:
- Parametrised frame sequencer between a source frame RAM, an image-processing core and a destination RAM; the next generation of the fixed 76800x8 load/feed/collect sequencing used around the gorev cores.
- On start, streams DEPTH pixels from source RAM to the core over a valid/ready handshake.
- Independently accepts DEPTH results from the core and writes them to destination RAM at sequential addresses.
- Reports progress counts and completion.

Parameters:
- DATA_W, 8: pixel and result width in bits.
- DEPTH, 76800: pixels per frame; legal range 1 to 2^ADDR_W.
- ADDR_W, 17: RAM address width.
- RD_LAT, 1: source RAM read latency in cycles, from address issue to valid src_data_i; legal range 1 to 4.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle start; sampled only in IDLE or DONE.
- src_en_o  out  1  source RAM enable (read only).
- src_addr_o  out  ADDR_W  source read address.
- src_data_i  in  DATA_W  source read data.
- core_data_o  out  DATA_W  pixel to core.
- core_valid_o  out  1  pixel valid.
- core_ready_i  in  1  core accepts pixel.
- res_data_i  in  DATA_W  result from core.
- res_valid_i  in  1  result valid.
- res_ready_o  out  1  controller accepts result.
- dst_en_o  out  1  destination RAM enable.
- dst_we_o  out  1  destination write strobe.
- dst_addr_o  out  ADDR_W  destination write address.
- dst_data_o  out  DATA_W  destination write data.
- busy_o  out  1  frame in progress.
- done_o  out  1  frame complete; sticky.
- in_count_o  out  ADDR_W+1  pixels accepted by the core.
- out_count_o  out  ADDR_W+1  results written.

Behaviour:
- Reset values: all outputs 0, both counters 0, top FSM in IDLE, feed FSM in F_IDLE.
- Top FSM IDLE -> RUN on start_i: clears both counters and done_o, sets busy_o.
  - RUN -> DONE when out_count reaches DEPTH.
  - In DONE: done_o=1, busy_o=0. DONE -> RUN on start_i, which clears done_o in the same edge.
  - start_i in RUN is ignored.
- Feed FSM runs while the top FSM is in RUN.
  - F_ISSUE: src_en_o=1, src_addr_o=in_count; then go to F_WAIT.
  - F_WAIT: count RD_LAT cycles, then latch src_data_i into core_data_o and go to F_PRESENT.
  - F_PRESENT: core_valid_o=1; core_data_o stays stable until core_ready_i.
  - On handshake: in_count increments. Go to F_ISSUE if in_count+1<DEPTH, else to F_IDLE with core_valid_o=0.
  - Throughput is one pixel per RD_LAT+2 cycles at most.
- Result side:
  - res_ready_o=1 while in RUN and out_count<DEPTH.
  - Each res_valid_i&&res_ready_o cycle registers dst_en_o=1, dst_we_o=1, dst_addr_o=out_count, dst_data_o=res_data_i for exactly one cycle; out_count increments.
  - Back-to-back results are accepted every cycle.
- Results may arrive before or after the feed finishes; there is no ordering coupling between the two sides.
- Results offered while not in RUN, or after DEPTH results, are not accepted: res_ready_o=0 and no write.
- Counters saturate at DEPTH.
- Reset mid-frame: immediate return to reset values with no further RAM writes; the partially written destination RAM is not cleared.
- DEPTH=1: one issue, one result, then DONE.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- When defined: adds output checksum_o, width DATA_W+ADDR_W+1, holding the unsigned sum of all results written this frame.
  - Cleared on start; updated on the same edge as each destination write.
  - Holds its value in DONE; reset value 0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- DEPTH=4, RD_LAT=1, source 10,20,30,40, core ready always, echoing result = pixel+1 one cycle later -> destination 11,21,31,41 at addresses 0-3; done_o=1; both counts 4.
- core_ready_i low for 5 cycles while core_valid_o=1 -> core_data_o stable; in_count unchanged; no extra source reads.
- Core emits 4 results in consecutive cycles after all inputs -> 4 writes on consecutive cycles; then res_ready_o=0; a fifth res_valid_i causes no write.
- RD_LAT=3 -> exactly 3 cycles from F_ISSUE exit to core_valid_o rise; data correct.
- rst_ni low at in_count=2 -> all outputs 0 asynchronously; start_i then reruns the frame from address 0.
- FRAME_CHECKSUM_EN with results 11,21,31,41 -> checksum_o=104 in DONE; restart clears it to 0.

Source files
------------

// File: rtl/frame_stream_ctrl.sv
// Frame sequencer: streams DEPTH source pixels to the core and collects DEPTH results into destination RAM.
// Latency: RD_LAT+2 cycles per pixel on the feed side; one result written per cycle; optional FRAME_CHECKSUM_EN adds checksum_o.
// Backpressure: core_ready_i stalls the presented pixel; res_ready_o drops outside RUN or once DEPTH results are written.
module frame_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    output logic                   src_en_o,
    output logic [ADDR_W-1:0]      src_addr_o,
    input  logic [DATA_W-1:0]      src_data_i,
    output logic [DATA_W-1:0]      core_data_o,
    output logic                   core_valid_o,
    input  logic                   core_ready_i,
    input  logic [DATA_W-1:0]      res_data_i,
    input  logic                   res_valid_i,
    output logic                   res_ready_o,
    output logic                   dst_en_o,
    output logic                   dst_we_o,
    output logic [ADDR_W-1:0]      dst_addr_o,
    output logic [DATA_W-1:0]      dst_data_o,
    output logic                   busy_o,
    output logic                   done_o,
`ifdef FRAME_CHECKSUM_EN
    output logic [DATA_W+ADDR_W:0] checksum_o,
`endif
    output logic [ADDR_W:0]        in_count_o,
    output logic [ADDR_W:0]        out_count_o
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [1:0]      LAT_M1  = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} top_t;
    typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_WAIT, F_PRESENT} feed_t;

    top_t               state_q, state_d;
    feed_t              fstate_q, fstate_d;
    logic [ADDR_W:0]    in_count_q, out_count_q;
    logic [1:0]         wait_cnt_q;
    logic [DATA_W-1:0]  core_data_q;
    logic               dst_wr_q;
    logic [ADDR_W-1:0]  dst_addr_q;
    logic [DATA_W-1:0]  dst_data_q;
    logic               start_go, in_hs, res_hs, latch;

    assign start_go     = start_i && (state_q != RUN);
    assign core_valid_o = (fstate_q == F_PRESENT);
    assign in_hs        = core_valid_o && core_ready_i;
    assign res_ready_o  = (state_q == RUN) && (out_count_q < DEPTH_C);
    assign res_hs       = res_valid_i && res_ready_o;
    assign src_en_o     = (fstate_q == F_ISSUE);
    assign src_addr_o   = src_en_o ? in_count_q[ADDR_W-1:0] : '0;
    assign core_data_o  = core_data_q;
    assign dst_en_o     = dst_wr_q;
    assign dst_we_o     = dst_wr_q;
    assign dst_addr_o   = dst_addr_q;
    assign dst_data_o   = dst_data_q;
    assign busy_o       = (state_q == RUN);
    assign done_o       = (state_q == DONE);
    assign in_count_o   = in_count_q;
    assign out_count_o  = out_count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = RUN;
            RUN:     if (res_hs && (out_count_q == DEPTH_C - 1'b1)) state_d = DONE;
            DONE:    if (start_go) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fstate_d = fstate_q;
        latch    = 1'b0;
        case (fstate_q)
            F_IDLE:    if (start_go) fstate_d = F_ISSUE;
            F_ISSUE:   fstate_d = F_WAIT;
            F_WAIT: begin
                if (wait_cnt_q == LAT_M1) begin
                    latch    = 1'b1;
                    fstate_d = F_PRESENT;
                end
            end
            F_PRESENT: begin
                if (core_ready_i)
                    fstate_d = (in_count_q + 1'b1 < DEPTH_C) ? F_ISSUE : F_IDLE;
            end
            default:   fstate_d = F_IDLE;
        endcase
        // The feed side only lives inside RUN; leaving RUN parks it.
        if (state_q == RUN && state_d != RUN)
            fstate_d = F_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            fstate_q    <= F_IDLE;
            wait_cnt_q  <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            core_data_q <= '0;
            dst_wr_q    <= 1'b0;
            dst_addr_q  <= '0;
            dst_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            fstate_q   <= fstate_d;
            wait_cnt_q <= (fstate_q == F_WAIT) ? wait_cnt_q + 2'd1 : 2'd0;
            if (latch)
                core_data_q <= src_data_i;
            dst_wr_q <= res_hs;
            if (res_hs) begin
                dst_addr_q <= out_count_q[ADDR_W-1:0];
                dst_data_q <= res_data_i;
            end
            if (start_go) begin
                in_count_q  <= '0;
                out_count_q <= '0;
            end else begin
                if (in_hs && in_count_q < DEPTH_C)
                    in_count_q <= in_count_q + 1'b1;
                if (res_hs)
                    out_count_q <= out_count_q + 1'b1;
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [DATA_W+ADDR_W:0] checksum_q;
    assign checksum_o = checksum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            checksum_q <= '0;
        else if (start_go)
            checksum_q <= '0;
        else if (res_hs)
            checksum_q <= checksum_q + (DATA_W+ADDR_W+1)'(res_data_i);
    end
`endif

endmodule
